// File: rtl/reg_bus_sched_pkg.sv
// Shared encodings for the register-bus scheduler: op codes and FSM state values.
package reg_bus_sched_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_WRITE = 2'b01,
    OP_INC   = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EXEC = 1'b1;

endpackage

// File: rtl/reg_bus_sched_if.sv
// Requester-side bundle of the shared register bus: flattened request fields in,
// acknowledge and one-hot register strobes out.
interface reg_bus_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int NUM_REG = 8,
  parameter int DATA_W  = 8
);
  localparam int IDX_W = $clog2(NUM_REG);

  logic [NUM_REQ-1:0]        req;
  logic [2*NUM_REQ-1:0]      op_flat;
  logic [IDX_W*NUM_REQ-1:0]  dst_flat;
  logic [DATA_W*NUM_REQ-1:0] data_flat;
  logic [NUM_REQ-1:0]        ack;
  logic [DATA_W-1:0]         BusOut;
  logic [NUM_REG-1:0]        Wen;
  logic [NUM_REG-1:0]        INC;
  logic [NUM_REG-1:0]        RST;
  logic                      busy;
  logic                      err;

  modport master (
    output req, op_flat, dst_flat, data_flat,
    input  ack, BusOut, Wen, INC, RST, busy, err
  );

  modport slave (
    input  req, op_flat, dst_flat, data_flat,
    output ack, BusOut, Wen, INC, RST, busy, err
  );

endinterface

// File: rtl/reg_bus_sched_rr_arbiter.sv
// Combinational arbiter: round-robin from rr_ptr, or lowest-index-wins when
// FIXED_PRIORITY_EN is defined (the rr_ptr port then disappears).
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
`ifndef FIXED_PRIORITY_EN
  input  logic [PTR_W-1:0]   rr_ptr,
`endif
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               valid
);

`ifdef FIXED_PRIORITY_EN
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    // Scan downwards so the lowest requesting index is the last one written.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[PTR_W'(i)]) begin
        grant              = '0;
        grant[PTR_W'(i)]   = 1'b1;
        grant_idx          = PTR_W'(i);
        valid              = 1'b1;
      end
    end
  end
`else
  int               idx;
  logic [PTR_W-1:0] idx_c;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    idx       = 0;
    idx_c     = '0;
    // Wrap explicitly: NUM_REQ need not be a power of two.
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = int'(rr_ptr) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_c = PTR_W'(idx);
      if (!valid && req[idx_c]) begin
        grant[idx_c] = 1'b1;
        grant_idx    = idx_c;
        valid        = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/reg_bus_sched.sv
// Two-state scheduler for the shared register bus; one transaction per two cycles.
// Build option: FIXED_PRIORITY_EN selects fixed lowest-index priority instead of round-robin.
module reg_bus_sched
  import reg_bus_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int NUM_REG = 8,
  parameter int DATA_W  = 8
) (
  input  logic            Clk,
  input  logic            RSTn,
  reg_bus_sched_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_REG);
  localparam int PTR_W = $clog2(NUM_REQ);

  logic [0:0]         state_reg;
  logic [NUM_REQ-1:0] ack_reg;
  logic [DATA_W-1:0]  bus_out_reg;
  logic [NUM_REG-1:0] wen_reg;
  logic [NUM_REG-1:0] inc_reg;
  logic [NUM_REG-1:0] rst_reg;
  logic               busy_reg;
  logic               err_reg;

  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   grant_idx;
  logic               grant_valid;

  op_e                win_op;
  logic [IDX_W-1:0]   win_dst;
  logic [DATA_W-1:0]  win_data;
  logic               dst_valid;
  logic [NUM_REG-1:0] dst_onehot;

`ifdef FIXED_PRIORITY_EN
  rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_arb (
    .req       (bus.req),
    .grant     (grant),
    .grant_idx (grant_idx),
    .valid     (grant_valid)
  );
`else
  logic [PTR_W-1:0] rr_ptr_reg;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_arb (
    .req       (bus.req),
    .rr_ptr    (rr_ptr_reg),
    .grant     (grant),
    .grant_idx (grant_idx),
    .valid     (grant_valid)
  );
`endif

  assign win_op    = op_e'(bus.op_flat[2*grant_idx +: 2]);
  assign win_dst   = bus.dst_flat[IDX_W*grant_idx +: IDX_W];
  assign win_data  = bus.data_flat[DATA_W*grant_idx +: DATA_W];
  assign dst_valid = int'(win_dst) < NUM_REG;

  // Out-of-range destinations decode to an all-zero mask, so no strobe can fire.
  for (genvar gi = 0; gi < NUM_REG; gi++) begin : g_dst
    assign dst_onehot[gi] = dst_valid && (win_dst == IDX_W'(gi));
  end

  always_ff @(posedge Clk) begin
    if (!RSTn) begin
      state_reg   <= ST_IDLE;
      ack_reg     <= '0;
      bus_out_reg <= '0;
      wen_reg     <= '0;
      inc_reg     <= '0;
      rst_reg     <= '0;
      busy_reg    <= 1'b0;
      err_reg     <= 1'b0;
`ifndef FIXED_PRIORITY_EN
      rr_ptr_reg  <= '0;
`endif
    end else begin
      // EXEC always lasts one cycle; every output is a pulse that drops here.
      state_reg   <= ST_IDLE;
      ack_reg     <= '0;
      bus_out_reg <= '0;
      wen_reg     <= '0;
      inc_reg     <= '0;
      rst_reg     <= '0;
      busy_reg    <= 1'b0;
      err_reg     <= 1'b0;
      if (state_reg == ST_IDLE && grant_valid) begin
        state_reg   <= ST_EXEC;
        ack_reg     <= grant;
        bus_out_reg <= win_data;
        wen_reg     <= (win_op == OP_WRITE) ? dst_onehot : '0;
        inc_reg     <= (win_op == OP_INC)   ? dst_onehot : '0;
        rst_reg     <= (win_op == OP_CLEAR) ? dst_onehot : '0;
        busy_reg    <= 1'b1;
        err_reg     <= !dst_valid;
`ifndef FIXED_PRIORITY_EN
        rr_ptr_reg  <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
`endif
      end
    end
  end

  assign bus.ack    = ack_reg;
  assign bus.BusOut = bus_out_reg;
  assign bus.Wen    = wen_reg;
  assign bus.INC    = inc_reg;
  assign bus.RST    = rst_reg;
  assign bus.busy   = busy_reg;
  assign bus.err    = err_reg;

endmodule

// File: tb/tb_reg_bus_sched.sv
// Directed bench for reg_bus_sched (NUM_REQ=4, NUM_REG=6 so an out-of-range dst is reachable).
// Honours FIXED_PRIORITY_EN for the contention ordering.
module tb_reg_bus_sched;

  localparam int NUM_REQ = 4;
  localparam int NUM_REG = 6;
  localparam int DATA_W  = 8;

  logic Clk = 1'b0;
  logic RSTn = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;

  reg_bus_sched_if #(.NUM_REQ(NUM_REQ), .NUM_REG(NUM_REG), .DATA_W(DATA_W)) bus ();

  reg_bus_sched #(.NUM_REQ(NUM_REQ), .NUM_REG(NUM_REG), .DATA_W(DATA_W)) dut (
    .Clk  (Clk),
    .RSTn (RSTn),
    .bus  (bus)
  );

  always #5 Clk = ~Clk;

  // Strobes must never overlap, in any cycle of any test.
  always @(negedge Clk) begin
    if (mon_en) begin
      n_checks++;
      if ($onehot0({bus.Wen, bus.INC, bus.RST}) !== 1'b1) begin
        n_fail++;
        $display("FAIL onehot0 strobes Wen=%b INC=%b RST=%b want at most one bit", bus.Wen, bus.INC, bus.RST);
      end
    end
  end

  task automatic set_req(input int i, input logic [1:0] op, input logic [2:0] dst, input logic [7:0] data);
    bus.op_flat[2*i +: 2]   = op;
    bus.dst_flat[3*i +: 3]  = dst;
    bus.data_flat[8*i +: 8] = data;
    bus.req[i]              = 1'b1;
  endtask

  task automatic do_reset();
    RSTn = 1'b0;
    bus.req = '0;
    repeat (2) @(negedge Clk);
    RSTn = 1'b1;
  endtask

  task automatic test_reset();
    RSTn = 1'b0;
    bus.req = '0;
    bus.op_flat = '0;
    bus.dst_flat = '0;
    bus.data_flat = '0;
    @(negedge Clk);
    set_req(0, 2'b01, 3'd1, 8'hAA);
    repeat (2) @(negedge Clk);
    mon_en = 1'b1;
    n_checks++;
    if ({bus.ack, bus.BusOut, bus.Wen, bus.INC, bus.RST, bus.busy, bus.err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs ack=%b BusOut=%h Wen=%b INC=%b RST=%b busy=%b err=%b want all 0",
               bus.ack, bus.BusOut, bus.Wen, bus.INC, bus.RST, bus.busy, bus.err);
    end
    bus.req = '0;
    RSTn = 1'b1;
    @(negedge Clk);
    $display("txn reset: outputs held at 0 while RSTn low");
  endtask

  task automatic test_write();
    do_reset();
    set_req(0, 2'b01, 3'd2, 8'd12);
    @(negedge Clk);
    n_checks++;
    if (bus.Wen !== 6'b000100 || bus.BusOut !== 8'd12 || bus.ack !== 4'b0001 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL write_exec Wen=%b BusOut=%0d ack=%b busy=%b want 000100 12 0001 1",
               bus.Wen, bus.BusOut, bus.ack, bus.busy);
    end
    n_checks++;
    if (bus.INC !== '0 || bus.RST !== '0 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL write_other INC=%b RST=%b err=%b want 0 0 0", bus.INC, bus.RST, bus.err);
    end
    bus.req = '0;
    @(negedge Clk);
    n_checks++;
    if ({bus.ack, bus.BusOut, bus.Wen, bus.busy} !== '0) begin
      n_fail++;
      $display("FAIL write_after ack=%b BusOut=%0d Wen=%b busy=%b want all 0", bus.ack, bus.BusOut, bus.Wen, bus.busy);
    end
    $display("txn write: req0 dst=2 data=12");
  endtask

  task automatic test_inc_clear();
    do_reset();
    set_req(1, 2'b10, 3'd5, 8'd7);
    @(negedge Clk);
    n_checks++;
    if (bus.INC !== 6'b100000 || bus.Wen !== '0 || bus.RST !== '0 || bus.ack !== 4'b0010) begin
      n_fail++;
      $display("FAIL inc_exec INC=%b Wen=%b RST=%b ack=%b want 100000 0 0 0010", bus.INC, bus.Wen, bus.RST, bus.ack);
    end
    // Change op while EXEC; req stays high, so a fresh CLEAR is taken two edges later.
    bus.op_flat[3:2] = 2'b11;
    @(negedge Clk);
    n_checks++;
    if ({bus.ack, bus.Wen, bus.INC, bus.RST, bus.busy} !== '0) begin
      n_fail++;
      $display("FAIL inc_gap ack=%b Wen=%b INC=%b RST=%b busy=%b want all 0", bus.ack, bus.Wen, bus.INC, bus.RST, bus.busy);
    end
    @(negedge Clk);
    n_checks++;
    if (bus.RST !== 6'b100000 || bus.INC !== '0 || bus.Wen !== '0 || bus.ack !== 4'b0010) begin
      n_fail++;
      $display("FAIL clear_exec RST=%b INC=%b Wen=%b ack=%b want 100000 0 0 0010", bus.RST, bus.INC, bus.Wen, bus.ack);
    end
    bus.req = '0;
    @(negedge Clk);
    n_checks++;
    if (bus.RST !== '0 || bus.ack !== '0) begin
      n_fail++;
      $display("FAIL clear_after RST=%b ack=%b want 0 0", bus.RST, bus.ack);
    end
    $display("txn inc_clear: req1 INC then CLEAR on dst=5");
  endtask

  task automatic test_back_to_back();
    int order[5];
    int cyc[5];
    int exp_order[5];
    int n_ack = 0;
    int cycle = 0;
    int idx;
`ifdef FIXED_PRIORITY_EN
    exp_order = '{0, 1, 2, 0, 3};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 2'b01, 3'(i), 8'(i + 1));
    while (n_ack < 5 && cycle < 30) begin
      @(negedge Clk);
      cycle++;
      if (bus.ack !== '0) begin
        idx = -1;
        for (int i = 0; i < NUM_REQ; i++) if (bus.ack[i] === 1'b1) idx = i;
        order[n_ack] = idx;
        cyc[n_ack] = cycle;
        n_checks++;
        if (!$onehot(bus.ack) || bus.BusOut !== 8'(idx + 1)) begin
          n_fail++;
          $display("FAIL rr_ack_data ack=%b BusOut=%0d want one-hot ack with BusOut=%0d", bus.ack, bus.BusOut, idx + 1);
        end
        $display("txn contention: ack #%0d to requester %0d at cycle %0d", n_ack, idx, cycle);
        if (idx >= 0) bus.req[idx] = 1'b0;
        // Re-request from 0 while 3 is still pending.
        if (n_ack == 2) bus.req[0] = 1'b1;
        n_ack++;
      end
    end
    n_checks++;
    if (n_ack != 5) begin
      n_fail++;
      $display("FAIL rr_timeout got %0d acks in %0d cycles want 5", n_ack, cycle);
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_checks++;
        if (order[k] != exp_order[k]) begin
          n_fail++;
          $display("FAIL rr_order[%0d] got requester %0d want %0d", k, order[k], exp_order[k]);
        end
      end
      for (int k = 1; k < 5; k++) begin
        n_checks++;
        if (cyc[k] - cyc[k-1] != 2) begin
          n_fail++;
          $display("FAIL rr_spacing[%0d] got %0d cycles want 2", k, cyc[k] - cyc[k-1]);
        end
      end
    end
    bus.req = '0;
    @(negedge Clk);
  endtask

  task automatic test_bad_dst();
    do_reset();
    set_req(3, 2'b01, 3'd7, 8'd55);
    @(negedge Clk);
    n_checks++;
    if (bus.ack !== 4'b1000 || bus.err !== 1'b1 || bus.BusOut !== 8'd55) begin
      n_fail++;
      $display("FAIL bad_dst_ack ack=%b err=%b BusOut=%0d want 1000 1 55", bus.ack, bus.err, bus.BusOut);
    end
    n_checks++;
    if (bus.Wen !== '0 || bus.INC !== '0 || bus.RST !== '0) begin
      n_fail++;
      $display("FAIL bad_dst_strobe Wen=%b INC=%b RST=%b want all 0", bus.Wen, bus.INC, bus.RST);
    end
    bus.req = '0;
    @(negedge Clk);
    n_checks++;
    if (bus.err !== 1'b0 || bus.ack !== '0) begin
      n_fail++;
      $display("FAIL bad_dst_after err=%b ack=%b want 0 0", bus.err, bus.ack);
    end
    $display("txn bad_dst: req3 dst=7 -> err");
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    set_req(1, 2'b01, 3'd1, 8'd9);
    @(negedge Clk);
    n_checks++;
    if (bus.busy !== 1'b1 || bus.Wen !== 6'b000010) begin
      n_fail++;
      $display("FAIL midrst_exec busy=%b Wen=%b want 1 000010", bus.busy, bus.Wen);
    end
    // req1 stays high through reset: no grant may be issued while RSTn is low.
    RSTn = 1'b0;
    @(negedge Clk);
    n_checks++;
    if ({bus.ack, bus.BusOut, bus.Wen, bus.INC, bus.RST, bus.busy, bus.err} !== '0) begin
      n_fail++;
      $display("FAIL midrst_outputs ack=%b BusOut=%0d Wen=%b busy=%b want all 0", bus.ack, bus.BusOut, bus.Wen, bus.busy);
    end
    @(negedge Clk);
    n_checks++;
    if (bus.ack !== '0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_hold ack=%b busy=%b want 0 0", bus.ack, bus.busy);
    end
    bus.req = '0;
    set_req(2, 2'b01, 3'd2, 8'd22);
    set_req(0, 2'b01, 3'd0, 8'd20);
    RSTn = 1'b1;
    @(negedge Clk);
    n_checks++;
    if (bus.ack !== 4'b0001 || bus.BusOut !== 8'd20) begin
      n_fail++;
      $display("FAIL midrst_first_grant ack=%b BusOut=%0d want 0001 20", bus.ack, bus.BusOut);
    end
    bus.req = '0;
    @(negedge Clk);
    $display("txn reset_mid_op: in-flight dropped, requester 0 granted first after release");
  endtask

  task automatic test_nop();
    do_reset();
    set_req(2, 2'b00, 3'd3, 8'd34);
    @(negedge Clk);
    n_checks++;
    if (bus.ack !== 4'b0100 || bus.BusOut !== 8'd34 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL nop_exec ack=%b BusOut=%0d busy=%b want 0100 34 1", bus.ack, bus.BusOut, bus.busy);
    end
    n_checks++;
    if (bus.Wen !== '0 || bus.INC !== '0 || bus.RST !== '0 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL nop_strobe Wen=%b INC=%b RST=%b err=%b want all 0", bus.Wen, bus.INC, bus.RST, bus.err);
    end
    bus.req = '0;
    @(negedge Clk);
    $display("txn nop: req2 dst=3 data=34");
  endtask

  initial begin
    test_reset();
    test_write();
    test_inc_clear();
    test_back_to_back();
    test_bad_dst();
    test_reset_mid_op();
    test_nop();
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
